cumulative_sum_engine: RTL
==========================

# cumulative_sum_engine

Parametrised successor to the fixed 1-to-10 accumulator processor. It sums an arithmetic series from `i_first` to `i_last` in steps of `i_step`, one term per clock. The run is controlled by a start/busy/done handshake, and both the result and the term count are buffered for the host. It sits beside the dedicated-processor blocks as a reusable control-unit plus datapath pair.

## Interface
- `N_W`, default 8: width of `i_first`, `i_last`, `i_step` and `o_count`.
- `SUM_W`, default 16: width of the accumulator and `o_sum`.

- `clk`, in, 1: the only clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a run; sampled only in IDLE.
- `i_first`, in, `N_W`: first term.
- `i_last`, in, `N_W`: last term bound, inclusive.
- `i_step`, in, `N_W`: increment; 0 is treated as 1.
- `busy`, out, 1: high in LOAD, RUN and DONE.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `o_sum`, out, `SUM_W`: buffered result; holds its value until the next DONE.
- `o_count`, out, `N_W`: number of terms added in the last run, buffered.
- `o_ovf`, out, 1: overflow flag (see Configuration).

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, `start`=1: latch `i_first`, `i_last` and the effective step; go to LOAD. With `start`=0, stay in IDLE.
- LOAD:
  - `n` ← first, where `n` is `N_W`+1 bits wide so it never wraps.
  - acc ← 0, cnt ← 0, ovf_int ← 0.
  - Go to RUN.
- RUN, when `n` ≤ last: acc ← acc + `n`, `n` ← `n` + step, cnt ← cnt + 1; stay in RUN.
- RUN, when `n` > last: `o_sum` ← acc, `o_count` ← cnt, `o_ovf` ← ovf_int; go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while `busy` is ignored; it is not queued.
- Input changes after the latching edge have no effect on the current run.
- `i_first` > `i_last`: zero terms are added, so `o_sum`=0 and `o_count`=0.
- `i_last` = 2^`N_W`−1: the run terminates correctly because of the extra bit in `n`.
- Arithmetic is unsigned. Each term is zero-extended to `SUM_W` before the add.

## Timing
- Reset value of every register and output is 0; the FSM resets to IDLE.
- Let edge 0 be the edge that samples `start`=1, and K the number of terms.
  - LOAD is entered after edge 0, RUN after edge 1.
  - Terms are added on edges 2 … K+1.
  - DONE is entered on edge K+2, together with the `o_sum`/`o_count` update.
  - `done` is high between edges K+2 and K+3.
- `busy` rises after edge 0 and falls after edge K+3.
- The earliest back-to-back `start` is the cycle after DONE, sampled on edge K+3.
- `rst` asserted mid-run aborts the run immediately: all outputs return to 0, including the previously buffered `o_sum`, and `done` does not pulse.

## Configuration
- Macro: `CUMULATIVE_SUM_SAT_EN`.
- Defined:
  - An add whose true result exceeds 2^`SUM_W`−1 clamps acc to all-ones and sets ovf_int.
  - ovf_int stays set for the rest of the run.
  - `o_ovf` reports it at DONE and holds until the next DONE or reset.
- Undefined:
  - The accumulator wraps modulo 2^`SUM_W`.
  - `o_ovf` is tied to 0 and no saturation logic is synthesised.

## Structure
- Shared package `cumulative_sum_pkg` holds:
  - the `state_e` enum {IDLE, LOAD, RUN, DONE};
  - default width constants `N_W_DEF`=8 and `SUM_W_DEF`=16.
- One sub-module, `cumulative_sum_datapath`, holds the `n`/acc/cnt registers, the comparator (drives `nle_last` to the FSM), the adder, the saturation logic and the output buffers.
- The FSM lives in the top module and drives the datapath's select and enable strobes.

## Test plan
- 1..10, step 1, defaults: `done` on edge 12, `o_sum`=55, `o_count`=10, `o_ovf`=0.
- first=5, last=3: `done` on edge 2, `o_sum`=0, `o_count`=0. Then first=last=7: `o_sum`=7, `o_count`=1.
- first=0, last=255, step 1, `N_W`=8, `SUM_W`=16: terminates with `o_sum`=32640 and `o_count`=256 mod 256=0. Also first=1, last=255: `o_count`=255, `o_sum`=32640. Step 0 on 1..4: behaves as step 1, `o_sum`=10.
- first=1, last=9, step 2: `o_sum`=25, `o_count`=5. A `start` pulse mid-run is ignored and the result is unchanged.
- `SUM_W`=8, 1..30: with the macro, `o_sum`=255 and `o_ovf`=1. Without the macro, `o_sum`=209 (465 mod 256) and `o_ovf`=0.
- After a completed 1..10 run, start 1..20 and assert `rst` on edge 5:
  - outputs go to 0 immediately and no `done` pulse occurs;
  - a new 1..10 run then yields 55.

Source files
------------

// File: rtl/cumulative_sum_pkg.sv
// cumulative_sum_pkg: shared FSM state type and default widths for the cumulative sum engine
package cumulative_sum_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
   localparam int N_W_DEF   = 8;
   localparam int SUM_W_DEF = 16;
endpackage

// File: rtl/cumulative_sum_datapath.sv
// cumulative_sum_datapath: term/acc/count registers, comparator, adder and output buffers; CUMULATIVE_SUM_SAT_EN enables saturation
module cumulative_sum_datapath
   import cumulative_sum_pkg::*;
#(
   parameter int N_W   = N_W_DEF,
   parameter int SUM_W = SUM_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             latch_i,
   input  logic             load_i,
   input  logic             add_i,
   input  logic             cap_i,
   input  logic [N_W-1:0]   first_i,
   input  logic [N_W-1:0]   last_i,
   input  logic [N_W-1:0]   step_i,
   output logic             nle_last_o,
   output logic [SUM_W-1:0] sum_o,
   output logic [N_W-1:0]   count_o,
   output logic             ovf_o
);
   logic [N_W-1:0]   first_q, last_q, step_q;
   logic [N_W:0]     n_q, n_d;
   logic [SUM_W-1:0] acc_q, acc_d, add_res, term, sum_q;
   logic [N_W-1:0]   cnt_q, cnt_d, count_q;
   logic             ovf_int_q, ovf_int_d, ovf_q, add_ovf;

   assign term       = SUM_W'(n_q);
   assign nle_last_o = n_q <= {1'b0, last_q};
   assign sum_o      = sum_q;
   assign count_o    = count_q;

`ifdef CUMULATIVE_SUM_SAT_EN
   logic [SUM_W:0] sum_x;
   assign sum_x   = {1'b0, acc_q} + {1'b0, term};
   assign add_ovf = sum_x[SUM_W];
   assign add_res = add_ovf ? '1 : sum_x[SUM_W-1:0];
   assign ovf_o   = ovf_q;
`else
   assign add_ovf = 1'b0;
   assign add_res = acc_q + term;
   assign ovf_o   = 1'b0;
`endif

   // next-state of the running registers: clear on load, advance one term on add
   always_comb begin
      n_d       = load_i ? {1'b0, first_q} : add_i ? n_q + {1'b0, step_q} : n_q;
      acc_d     = load_i ? '0 : add_i ? add_res : acc_q;
      cnt_d     = load_i ? '0 : add_i ? cnt_q + 1'b1 : cnt_q;
      ovf_int_d = load_i ? 1'b0 : (ovf_int_q | (add_i & add_ovf));
   end

   // operand latch, running state and host-visible result buffers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q   <= '0;
         last_q    <= '0;
         step_q    <= '0;
         n_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_int_q <= 1'b0;
         sum_q     <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (latch_i) begin
            first_q <= first_i;
            last_q  <= last_i;
            step_q  <= (step_i == '0) ? N_W'(1) : step_i;
         end
         n_q       <= n_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_int_q <= ovf_int_d;
         if (cap_i) begin
            sum_q   <= acc_q;
            count_q <= cnt_q;
            ovf_q   <= ovf_int_q;
         end
      end
   end
endmodule

// File: rtl/cumulative_sum_engine.sv
// cumulative_sum_engine: start/busy/done controller around the series-sum datapath; CUMULATIVE_SUM_SAT_EN enables saturation
module cumulative_sum_engine
   import cumulative_sum_pkg::*;
#(
   parameter int N_W   = N_W_DEF,
   parameter int SUM_W = SUM_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   i_first,
   input  logic [N_W-1:0]   i_last,
   input  logic [N_W-1:0]   i_step,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] o_sum,
   output logic [N_W-1:0]   o_count,
   output logic             o_ovf
);
   state_e state_q, state_d;
   logic   nle_last, latch, load, add, cap;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state and datapath strobes
   always_comb begin
      state_d = state_q;
      latch   = (state_q == IDLE) & start;
      load    = state_q == LOAD;
      add     = (state_q == RUN) & nle_last;
      cap     = (state_q == RUN) & ~nle_last;
      busy    = state_q != IDLE;
      done    = state_q == DONE;
      case (state_q)
         IDLE:    state_d = start ? LOAD : IDLE;
         LOAD:    state_d = RUN;
         RUN:     state_d = nle_last ? RUN : DONE;
         default: state_d = IDLE;
      endcase
   end

   cumulative_sum_datapath #(.N_W(N_W), .SUM_W(SUM_W)) u_dp (
      .clk        (clk),
      .rst        (rst),
      .latch_i    (latch),
      .load_i     (load),
      .add_i      (add),
      .cap_i      (cap),
      .first_i    (i_first),
      .last_i     (i_last),
      .step_i     (i_step),
      .nle_last_o (nle_last),
      .sum_o      (o_sum),
      .count_o    (o_count),
      .ovf_o      (o_ovf)
   );
endmodule
